// File: rtl/robot_pkg.sv
// rtl/robot_pkg.sv - shared encodings and widths for the cleaning job scheduler
`timescale 1ns/1ps
package robot_pkg;

  localparam int DAY_MIN = 1440;
  localparam int TIME_W  = 11;
  localparam int DUR_W   = 6;
  localparam int FUNC_W  = 2;

  typedef enum logic [FUNC_W-1:0] {
    FUNC_VAC   = 2'd0,
    FUNC_SAN   = 2'd1,
    FUNC_MOP   = 2'd2,
    FUNC_COMBO = 2'd3
  } func_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_LOAD  = 2'd1,
    S_RUN   = 2'd2,
    S_PAUSE = 2'd3
  } sched_state_e;

endpackage

// File: rtl/sched_slot_table.sv
// rtl/sched_slot_table.sv - job slot storage, start-time match, pending flags and lowest-index pick
//   clk_i/rst_i        : clock, asynchronous active-high reset
//   wr_*_i             : one-slot write port (wr_valid_i=0 deletes the slot)
//   real_time_i        : real-time minute count
//   take_i/take_slot_i : scheduler consumes the picked slot this cycle
//   any_pending_o, pick_*_o : lowest-index pending slot and its fields
//   missed_o           : sticky, a slot matched while still pending
`timescale 1ns/1ps
module sched_slot_table
  import robot_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic [SLOT_W-1:0] wr_slot_i,
  input  logic              wr_valid_i,
  input  logic              wr_repeat_i,
  input  logic [TIME_W-1:0] wr_time_i,
  input  func_e             wr_func_i,
  input  logic [DUR_W-1:0]  wr_dur_i,
  input  logic [TIME_W-1:0] real_time_i,
  input  logic              take_i,
  input  logic [SLOT_W-1:0] take_slot_i,
  output logic              any_pending_o,
  output logic [SLOT_W-1:0] pick_slot_o,
  output func_e             pick_func_o,
  output logic [DUR_W-1:0]  pick_dur_o,
  output logic              missed_o
);

  logic [NUM_SLOTS-1:0] valid_q, valid_d;
  logic [NUM_SLOTS-1:0] repeat_q, repeat_d;
  logic [NUM_SLOTS-1:0] pending_q, pending_d;
  logic [TIME_W-1:0]    time_q [NUM_SLOTS];
  logic [TIME_W-1:0]    time_d [NUM_SLOTS];
  func_e                func_q [NUM_SLOTS];
  func_e                func_d [NUM_SLOTS];
  logic [DUR_W-1:0]     dur_q  [NUM_SLOTS];
  logic [DUR_W-1:0]     dur_d  [NUM_SLOTS];
  logic                 missed_q, missed_d;
  logic [TIME_W-1:0]    prev_time_q;
  logic                 tick;

  assign tick = (real_time_i != prev_time_q);

  // Order matters: consume first, then match, then the write overrides both
  // so a write always leaves its slot non-pending.
  always_comb begin
    valid_d   = valid_q;
    repeat_d  = repeat_q;
    pending_d = pending_q;
    time_d    = time_q;
    func_d    = func_q;
    dur_d     = dur_q;
    missed_d  = missed_q;

    if (take_i) begin
      pending_d[take_slot_i] = 1'b0;
      if (!repeat_q[take_slot_i]) valid_d[take_slot_i] = 1'b0;
    end

    if (tick) begin
      for (int i = 0; i < NUM_SLOTS; i++) begin
        if (valid_q[i] && (time_q[i] == real_time_i)) begin
          if (pending_d[i]) missed_d = 1'b1;
          else              pending_d[i] = 1'b1;
        end
      end
    end

    if (wr_en_i) begin
      valid_d[wr_slot_i]   = wr_valid_i;
      repeat_d[wr_slot_i]  = wr_repeat_i;
      time_d[wr_slot_i]    = wr_time_i;
      func_d[wr_slot_i]    = wr_func_i;
      dur_d[wr_slot_i]     = wr_dur_i;
      pending_d[wr_slot_i] = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q     <= '0;
      repeat_q    <= '0;
      pending_q   <= '0;
      missed_q    <= 1'b0;
      prev_time_q <= '0;
      for (int i = 0; i < NUM_SLOTS; i++) begin
        time_q[i] <= '0;
        func_q[i] <= FUNC_VAC;
        dur_q[i]  <= '0;
      end
    end else begin
      valid_q     <= valid_d;
      repeat_q    <= repeat_d;
      pending_q   <= pending_d;
      missed_q    <= missed_d;
      prev_time_q <= real_time_i;
      time_q      <= time_d;
      func_q      <= func_d;
      dur_q       <= dur_d;
    end
  end

  always_comb begin
    logic found;
    found       = 1'b0;
    pick_slot_o = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (pending_q[i] && !found) begin
        pick_slot_o = SLOT_W'(i);
        found       = 1'b1;
      end
    end
  end

  assign any_pending_o = |pending_q;
  assign pick_func_o   = func_q[pick_slot_o];
  assign pick_dur_o    = dur_q[pick_slot_o];
  assign missed_o      = missed_q;

endmodule

// File: rtl/clean_job_scheduler.sv
// rtl/clean_job_scheduler.sv - dispatches scheduled cleaning jobs to the counter/decoder path
//   Clock/Reset            : clock, asynchronous active-high reset
//   WrEn..WrDur            : slot programming port
//   realTime               : real-time minute count
//   Battery/Cancel         : pause on low battery, abort active job
//   Remaining              : counter value fed back
//   Confirm/Duration/FunctionSelect : counter load strobe and job fields
//   Run/Busy/ActiveSlot/JobDone/Missed : job status
`timescale 1ns/1ps
module clean_job_scheduler
  import robot_pkg::*;
#(
  parameter int NUM_SLOTS = 4,
  parameter int SLOT_W    = 2
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              WrEn,
  input  logic [SLOT_W-1:0] WrSlot,
  input  logic              WrValid,
  input  logic              WrRepeat,
  input  logic [10:0]       WrTime,
  input  logic [1:0]        WrFunc,
  input  logic [5:0]        WrDur,
  input  logic [10:0]       realTime,
  input  logic              Battery,
  input  logic              Cancel,
  input  logic [5:0]        Remaining,
  output logic              Confirm,
  output logic [5:0]        Duration,
  output logic [1:0]        FunctionSelect,
  output logic              Run,
  output logic              Busy,
  output logic [SLOT_W-1:0] ActiveSlot,
  output logic              JobDone,
  output logic              Missed
);

  sched_state_e      state_q, state_d;
  func_e             func_q, func_d;
  logic [DUR_W-1:0]  dur_q, dur_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
  logic              take;
  logic              job_done;

  logic              any_pending;
  logic [SLOT_W-1:0] pick_slot;
  func_e             pick_func;
  logic [DUR_W-1:0]  pick_dur;

  sched_slot_table #(
    .NUM_SLOTS(NUM_SLOTS),
    .SLOT_W   (SLOT_W)
  ) u_table (
    .clk_i        (Clock),
    .rst_i        (Reset),
    .wr_en_i      (WrEn),
    .wr_slot_i    (WrSlot),
    .wr_valid_i   (WrValid),
    .wr_repeat_i  (WrRepeat),
    .wr_time_i    (WrTime),
    .wr_func_i    (func_e'(WrFunc)),
    .wr_dur_i     (WrDur),
    .real_time_i  (realTime),
    .take_i       (take),
    .take_slot_i  (pick_slot),
    .any_pending_o(any_pending),
    .pick_slot_o  (pick_slot),
    .pick_func_o  (pick_func),
    .pick_dur_o   (pick_dur),
    .missed_o     (Missed)
  );

  always_comb begin
    state_d  = state_q;
    func_d   = func_q;
    dur_d    = dur_q;
    slot_d   = slot_q;
    take     = 1'b0;
    job_done = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (any_pending) begin
          take   = 1'b1;
          slot_d = pick_slot;
          func_d = pick_func;
          dur_d  = pick_dur;
          // A zero-length job is consumed but never reaches the counter.
          if (pick_dur != '0) state_d = S_LOAD;
        end
      end
      S_LOAD:  state_d = S_RUN;
      S_RUN: begin
        if (Cancel)                 state_d = S_IDLE;
        else if (!Battery)          state_d = S_PAUSE;
        else if (Remaining == '0) begin
          state_d  = S_IDLE;
          job_done = 1'b1;
        end
      end
      S_PAUSE: begin
        if (Cancel)       state_d = S_IDLE;
        else if (Battery) state_d = S_RUN;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      func_q  <= FUNC_VAC;
      dur_q   <= '0;
      slot_q  <= '0;
    end else begin
      state_q <= state_d;
      func_q  <= func_d;
      dur_q   <= dur_d;
      slot_q  <= slot_d;
    end
  end

  // Status decoded straight from state so an asynchronous reset drops them at once.
  assign Confirm        = (state_q == S_LOAD);
  assign Run            = (state_q == S_RUN);
  assign Busy           = (state_q != S_IDLE);
  assign JobDone        = job_done;
  assign Duration       = dur_q;
  assign FunctionSelect = func_q;
  assign ActiveSlot     = slot_q;

endmodule
